// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package inst_fetch_pkg;

    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned INST_W_DEF = 10;

    // Instruction layout: [opcode 4][rs/rt 3][rt/imm/target 3]
    localparam int unsigned OPC_W   = 4;
    localparam int unsigned OPC_MSB = 9;
    localparam int unsigned OPC_LSB = 6;

    localparam logic [OPC_W-1:0] HALT_OPCODE = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HALT
    } state_t;

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch stage: drives the ROM address from the PC, registers the
// returned instruction toward decode, and handles stall, branch redirect and halt.
module inst_fetch #(
    parameter int unsigned ADDR_W = inst_fetch_pkg::ADDR_W_DEF,
    parameter int unsigned INST_W = inst_fetch_pkg::INST_W_DEF
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              Start,
    output logic [ADDR_W-1:0] InstAddress,
    input  logic [INST_W-1:0] InstIn,
    input  logic              BranchTaken,
    input  logic [ADDR_W-1:0] BranchTarget,
    output logic [INST_W-1:0] InstOut,
    output logic [ADDR_W-1:0] InstPC,
    output logic              FetchValid,
    input  logic              DecodeReady,
    output logic              Halted,
    output logic [15:0]       FetchCount
);

    import inst_fetch_pkg::*;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst_q;
    logic [ADDR_W-1:0] inst_pc;
    logic              fetch_valid;
    logic [15:0]       fetch_count;

    logic              slot_free;
    logic              is_halt;
    logic              capture;
    logic              redirect;

    assign slot_free = !fetch_valid || DecodeReady;
    assign is_halt   = (InstIn[INST_W-1 -: OPC_W] == HALT_OPCODE);

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus the capture/redirect strobes; a branch beats both stall and halt.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        redirect   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (Start) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (BranchTaken) begin
                    redirect = 1'b1;
                end else if (slot_free) begin
                    capture = 1'b1;
                    if (is_halt) begin
                        state_next = ST_HALT;
                    end
                end
            end
            ST_HALT: begin
                if (Start) begin
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // PC, fetched-instruction register and saturating capture counter.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pc          <= '0;
            inst_q      <= '0;
            inst_pc     <= '0;
            fetch_valid <= 1'b0;
            fetch_count <= '0;
        end else if (redirect) begin
            pc          <= BranchTarget;
            fetch_valid <= 1'b0;
        end else if (capture) begin
            inst_q      <= InstIn;
            inst_pc     <= pc;
            fetch_valid <= 1'b1;
            pc          <= pc + ADDR_W'(1);
            if (fetch_count != '1) begin
                fetch_count <= fetch_count + 16'd1;
            end
        end else if (fetch_valid && DecodeReady) begin
            fetch_valid <= 1'b0;
        end
    end

    assign InstAddress = pc;
    assign InstOut     = inst_q;
    assign InstPC      = inst_pc;
    assign FetchValid  = fetch_valid;
    assign FetchCount  = fetch_count;
    assign Halted      = (state == ST_HALT);

endmodule
